led_pattern_ctrl: RTL and testbench
===================================

Name: led_pattern_ctrl

Overview:
Sequencer for the board status LED. It accepts mode commands over a valid/ready handshake and drives LED through these patterns: off, on, periodic blink at slow/fast rate, or a counted burst of pulses. A free-running prescaler derives a tick from the 50 MHz clk, and all pattern timing is counted in ticks. Sits between top-level status logic and the LED pin.

Parameters:
TICK_DIV, 50000, clk cycles per tick (1 ms at 50 MHz); must be >= 2.
SLOW_TICKS, 500, blink half-period for rate 0.
FAST_TICKS, 100, blink half-period for rate 1.
PULSE_TICKS, 200, burst on-time and off-time per pulse.
CNT_W, 8, width of burst pulse count.

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous reset, active-high
cmd_valid  input  1  command offered
cmd_ready  output  1  controller can accept command
cmd_mode  input  2  0=OFF, 1=ON, 2=BLINK, 3=BURST
cmd_rate  input  1  BLINK rate: 0=SLOW_TICKS, 1=FAST_TICKS
cmd_count  input  CNT_W  BURST pulse count
LED  output  1  LED drive, registered
busy  output  1  high while BURST in progress
done  output  1  one-cycle pulse at BURST completion

Behaviour:
- Reset (async, rst=1): state S_OFF, saved mode OFF, prescaler/phase/pulse counters 0, LED=0, busy=0, done=0, cmd_ready=1.
- Accept = cmd_valid && cmd_ready at a rising clk edge. Command fields are sampled only on that edge.
- On accept, prescaler and phase counter clear. State and LED update on the accepting edge, so the new LED value is visible the cycle after.
- States: S_OFF (LED=0), S_ON (LED=1), S_BLINK, S_BURST_ON, S_BURST_OFF.
- cmd_ready = 1 in S_OFF/S_ON/S_BLINK and 0 in both BURST states. A burst cannot be pre-empted; only rst aborts it.
- OFF and ON commands: enter the state and remember it as the saved mode.
- BLINK command: LED=1 on accept. LED toggles every HP*TICK_DIV cycles, where HP is SLOW_TICKS or FAST_TICKS latched on accept. BLINK and its latched rate become the saved mode. Re-accepting BLINK restarts the phase with LED=1.
- BURST command with count N>0:
  - Latch N and enter S_BURST_ON with LED=1 and busy=1.
  - After PULSE_TICKS ticks, go to S_BURST_OFF with LED=0.
  - After PULSE_TICKS more ticks, decrement the remaining count. If it is nonzero, return to S_BURST_ON.
  - Otherwise, on that edge: done=1 for one cycle, busy=0, cmd_ready=1, and the block re-enters the saved mode. OFF/ON restore their LED level; BLINK restarts its phase with LED=1 and its saved rate.
  - Total burst duration is exactly 2*N*PULSE_TICKS*TICK_DIV cycles.
- BURST with N=0: the accepting edge leaves state and LED unchanged; done=1 on the following cycle; busy stays 0.
- A command presented during a burst is held off by cmd_ready=0. It is accepted at the first edge after done, not on the done edge itself.
- Tick: the prescaler counts 0..TICK_DIV-1 and tick asserts on wrap. Phase counter width is clog2 of max(SLOW_TICKS, FAST_TICKS, PULSE_TICKS)+1; the counter clears on each transition and never wraps.
- rst asserted mid-burst: immediate return to the reset values. The saved mode is lost (OFF).

Optional Feature:
LED_PWM_EN.
- Defined: adds input bright[3:0] and a 4-bit free-running PWM counter. LED = pattern_level && (pwm_cnt < bright). bright=15 gives 15/16 duty; bright=0 forces LED=0. bright is sampled live, not latched. The PWM counter resets to 0 on rst.
- Undefined: no bright port; LED = pattern_level exactly.

Test Plan:
Sim parameters for all scenarios: TICK_DIV=4, SLOW_TICKS=3, FAST_TICKS=1, PULSE_TICKS=2.
- Reset: rst=1 for 3 cycles, then release -> LED=0, busy=0, done=0, cmd_ready=1; with no commands, LED stays 0 for 100 cycles.
- BLINK slow: mode=2, rate=0 accepted -> LED=1, then toggles every 12 cycles for ≥4 toggles. Re-issue with rate=1 -> LED=1, then toggles every 4 cycles.
- BURST N=2 from ON:
  - LED 1/0/1/0 for 8 cycles each; busy=1 throughout; cmd_ready=0.
  - done pulses exactly 32 cycles after accept; LED returns to 1; busy=0.
- Hold-off: during BURST N=3, cmd_valid held with mode=0 -> no accept until the cycle after done, then LED=0.
- BURST N=0 from BLINK -> done pulses one cycle after accept; LED blink phase undisturbed; busy never rises.
- Async reset mid-burst: rst pulsed between clk edges during S_BURST_ON -> LED=0 and busy=0 immediately; no done pulse. After release, cmd_ready=1 and saved mode is OFF.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// Status LED sequencer: OFF / ON / BLINK (slow or fast) / counted BURST of pulses.
// Latency: a command is accepted on a rising clk edge and its LED level is visible the following cycle.
// Backpressure: cmd_ready drops for the whole burst, so a held command waits until the cycle after done.
//
// Ports:
//   clk, rst                 50 MHz clock, asynchronous active-high reset
//   cmd_valid / cmd_ready    command handshake; cmd_mode, cmd_rate and cmd_count are sampled on accept
//   LED                      registered LED drive
//   busy                     high while a burst runs
//   done                     one-cycle pulse when a burst completes (or when a zero-count burst is accepted)
//   bright[3:0]              PWM brightness, present only when LED_PWM_EN is defined
//
// Optional feature macro: LED_PWM_EN. When defined, LED = pattern_level && (pwm_cnt < bright),
// where pwm_cnt is a 4-bit free-running counter and bright is used live.
module led_pattern_ctrl #(
  parameter int TICK_DIV    = 50000,
  parameter int SLOW_TICKS  = 500,
  parameter int FAST_TICKS  = 100,
  parameter int PULSE_TICKS = 200,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic             cmd_rate,
  input  logic [CNT_W-1:0] cmd_count,
`ifdef LED_PWM_EN
  input  logic [3:0]       bright,
`endif
  output logic             LED,
  output logic             busy,
  output logic             done
);

  localparam int MAX_SF = (SLOW_TICKS > FAST_TICKS) ? SLOW_TICKS : FAST_TICKS;
  localparam int MAX_T  = (MAX_SF > PULSE_TICKS) ? MAX_SF : PULSE_TICKS;
  localparam int PH_W   = $clog2(MAX_T + 1);
  localparam int PS_W   = $clog2(TICK_DIV);

  localparam logic [PS_W-1:0] PS_LAST    = PS_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] SLOW_LAST  = PH_W'(SLOW_TICKS - 1);
  localparam logic [PH_W-1:0] FAST_LAST  = PH_W'(FAST_TICKS - 1);
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_TICKS - 1);

  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_BURST = 2'd3;

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_ON        = 3'd1,
    S_BLINK     = 3'd2,
    S_BURST_ON  = 3'd3,
    S_BURST_OFF = 3'd4
  } state_t;

  state_t           state, state_nxt;
  state_t           saved, saved_nxt;     // mode to resume after a burst (OFF/ON/BLINK only)
  logic             rate, rate_nxt;       // blink rate, latched with the BLINK command
  logic [PS_W-1:0]  presc, presc_nxt;
  logic [PH_W-1:0]  phase, phase_nxt;     // ticks elapsed in the current half-period
  logic [CNT_W-1:0] rem, rem_nxt;         // pulses remaining in the burst, including the current one
  logic             level, level_nxt;     // pattern level before any PWM gating
  logic             done_nxt;
  logic             led_d;
  logic             led_q;

  logic             tick;
  logic             accept;
  logic [PH_W-1:0]  hp_last;

  assign tick    = (presc == PS_LAST);
  assign accept  = cmd_valid && cmd_ready;
  assign hp_last = rate ? FAST_LAST : SLOW_LAST;

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 4'd1;
  end

  assign led_d = level_nxt && (pwm_cnt < bright);
`else
  assign led_d = level_nxt;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_OFF;
      saved <= S_OFF;
      rate  <= 1'b0;
      presc <= '0;
      phase <= '0;
      rem   <= '0;
      level <= 1'b0;
      led_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      rate  <= rate_nxt;
      presc <= presc_nxt;
      phase <= phase_nxt;
      rem   <= rem_nxt;
      level <= level_nxt;
      led_q <= led_d;
      done  <= done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    rate_nxt  = rate;
    presc_nxt = tick ? '0 : presc + 1'b1;
    phase_nxt = phase;
    rem_nxt   = rem;
    level_nxt = level;
    done_nxt  = 1'b0;

    case (state)
      S_OFF, S_ON, S_BLINK: begin
        if (accept) begin
          if (cmd_mode == M_BURST) begin
            if (cmd_count != '0) begin
              state_nxt = S_BURST_ON;
              level_nxt = 1'b1;
              rem_nxt   = cmd_count;
              presc_nxt = '0;
              phase_nxt = '0;
            end else begin
              // Empty burst: acknowledge only, leaving the running pattern and its timing alone.
              done_nxt = 1'b1;
            end
          end else begin
            presc_nxt = '0;
            phase_nxt = '0;
            case (cmd_mode)
              M_ON: begin
                state_nxt = S_ON;
                saved_nxt = S_ON;
                level_nxt = 1'b1;
              end
              M_BLINK: begin
                state_nxt = S_BLINK;
                saved_nxt = S_BLINK;
                rate_nxt  = cmd_rate;
                level_nxt = 1'b1;
              end
              default: begin
                state_nxt = S_OFF;
                saved_nxt = S_OFF;
                level_nxt = 1'b0;
              end
            endcase
          end
        end else if ((state == S_BLINK) && tick) begin
          if (phase == hp_last) begin
            level_nxt = ~level;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
      end

      S_BURST_ON: begin
        if (tick) begin
          if (phase == PULSE_LAST) begin
            state_nxt = S_BURST_OFF;
            level_nxt = 1'b0;
            phase_nxt = '0;
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
      end

      S_BURST_OFF: begin
        if (tick) begin
          if (phase == PULSE_LAST) begin
            phase_nxt = '0;
            if (rem == CNT_W'(1)) begin
              // Last pulse finished: resume the saved mode; a saved BLINK restarts high.
              done_nxt  = 1'b1;
              rem_nxt   = '0;
              state_nxt = saved;
              level_nxt = (saved != S_OFF);
              presc_nxt = '0;
            end else begin
              rem_nxt   = rem - CNT_W'(1);
              state_nxt = S_BURST_ON;
              level_nxt = 1'b1;
            end
          end else begin
            phase_nxt = phase + 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_OFF;
        level_nxt = 1'b0;
      end
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state == S_BURST_ON) || (state == S_BURST_OFF);
    cmd_ready = !busy;
    LED       = led_q;
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_DIV=4, SLOW=3, FAST=1, PULSE=2.
// Expected output values are queued with the cycle they are due and compared on the falling edge.
module tb_led_pattern_ctrl;

  localparam int SIG_LED  = 0;
  localparam int SIG_BUSY = 1;
  localparam int SIG_DONE = 2;
  localparam int SIG_RDY  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_mode = 2'd0;
  logic       cmd_rate = 1'b0;
  logic [7:0] cmd_count = 8'd0;
  logic       cmd_ready, led, busy, done;

  led_pattern_ctrl #(
    .TICK_DIV(4), .SLOW_TICKS(3), .FAST_TICKS(1), .PULSE_TICKS(2), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_rate(cmd_rate), .cmd_count(cmd_count),
    .LED(led), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    at;
    int    sig;
    logic  val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic cmp(string tag, logic obs, logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic expect_at(int at, int sig, logic val, string tag);
    exp_t e;
    e.at = at; e.sig = sig; e.val = val; e.tag = tag;
    sb.push_back(e);
  endtask

  function automatic logic sig_val(int sig);
    case (sig)
      SIG_LED:  return led;
      SIG_BUSY: return busy;
      SIG_DONE: return done;
      default:  return cmd_ready;
    endcase
  endfunction

  task automatic check_now();
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        cmp(sb[i].tag, sig_val(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  endtask

  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      check_now();
    end
  endtask

  task automatic drive(logic [1:0] m, logic r, logic [7:0] c);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_rate  = r;
    cmd_count = c;
  endtask

  initial begin
    int acc;
    int base;

    // Reset held across three rising edges.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp("rst_led", led, 1'b0);
    cmp("rst_busy", busy, 1'b0);
    cmp("rst_done", done, 1'b0);
    cmp("rst_rdy", cmd_ready, 1'b1);
    base = cyc;
    for (int k = 1; k <= 100; k++) expect_at(base + k, SIG_LED, 1'b0, "idle_led");
    expect_at(base + 100, SIG_RDY, 1'b1, "idle_rdy");
    run(100);

    // BLINK slow: half-period 3 ticks * 4 = 12 cycles.
    acc = cyc + 1;
    for (int k = 0; k < 60; k++) expect_at(acc + k, SIG_LED, ((k / 12) % 2) == 0, "blink_slow_led");
    expect_at(acc, SIG_RDY, 1'b1, "blink_slow_rdy");
    drive(2'd2, 1'b0, 8'd0);
    run(1);
    cmd_valid = 1'b0;
    run(59);

    // BLINK fast re-issued: restarts high, half-period 4 cycles.
    acc = cyc + 1;
    for (int k = 0; k < 24; k++) expect_at(acc + k, SIG_LED, ((k / 4) % 2) == 0, "blink_fast_led");
    drive(2'd2, 1'b1, 8'd0);
    run(1);
    cmd_valid = 1'b0;
    run(23);

    // ON.
    acc = cyc + 1;
    for (int k = 0; k < 4; k++) expect_at(acc + k, SIG_LED, 1'b1, "on_led");
    drive(2'd1, 1'b0, 8'd0);
    run(1);
    cmd_valid = 1'b0;
    run(3);

    // BURST N=2 from ON: 8-cycle phases, done 32 cycles after accept, LED back to 1.
    acc = cyc + 1;
    for (int k = 0; k < 32; k++) begin
      expect_at(acc + k, SIG_LED, ((k / 8) % 2) == 0, "burst2_led");
      expect_at(acc + k, SIG_BUSY, 1'b1, "burst2_busy");
      expect_at(acc + k, SIG_RDY, 1'b0, "burst2_rdy");
      expect_at(acc + k, SIG_DONE, 1'b0, "burst2_done_early");
    end
    expect_at(acc + 32, SIG_DONE, 1'b1, "burst2_done");
    expect_at(acc + 32, SIG_LED, 1'b1, "burst2_restore_led");
    expect_at(acc + 32, SIG_BUSY, 1'b0, "burst2_busy_end");
    expect_at(acc + 32, SIG_RDY, 1'b1, "burst2_rdy_end");
    expect_at(acc + 33, SIG_DONE, 1'b0, "burst2_done_once");
    expect_at(acc + 33, SIG_LED, 1'b1, "burst2_led_after");
    drive(2'd3, 1'b0, 8'd2);
    run(1);
    cmd_valid = 1'b0;
    run(33);

    // Hold-off: OFF command held through a BURST N=3, accepted the cycle after done.
    acc = cyc + 1;
    for (int k = 0; k < 48; k++) begin
      expect_at(acc + k, SIG_LED, ((k / 8) % 2) == 0, "hold_led");
      expect_at(acc + k, SIG_RDY, 1'b0, "hold_rdy");
      expect_at(acc + k, SIG_DONE, 1'b0, "hold_done_early");
    end
    expect_at(acc + 48, SIG_DONE, 1'b1, "hold_done");
    expect_at(acc + 48, SIG_LED, 1'b1, "hold_led_on_done_edge");
    expect_at(acc + 48, SIG_RDY, 1'b1, "hold_rdy_end");
    expect_at(acc + 49, SIG_LED, 1'b0, "hold_off_accepted");
    expect_at(acc + 49, SIG_DONE, 1'b0, "hold_done_once");
    drive(2'd3, 1'b0, 8'd3);
    run(1);
    cmd_mode  = 2'd0;
    cmd_count = 8'd0;
    run(49);
    cmd_valid = 1'b0;
    run(2);

    // BURST N=0 while blinking slow: done next cycle, blink timing untouched, busy stays low.
    acc = cyc + 1;
    for (int k = 0; k < 48; k++) begin
      expect_at(acc + k, SIG_LED, ((k / 12) % 2) == 0, "n0_blink_led");
      expect_at(acc + k, SIG_BUSY, 1'b0, "n0_busy");
    end
    drive(2'd2, 1'b0, 8'd0);
    run(1);
    cmd_valid = 1'b0;
    run(5);
    expect_at(cyc + 1, SIG_DONE, 1'b1, "n0_done");
    expect_at(cyc + 1, SIG_RDY, 1'b1, "n0_rdy");
    expect_at(cyc + 2, SIG_DONE, 1'b0, "n0_done_once");
    drive(2'd3, 1'b0, 8'd0);
    run(1);
    cmd_valid = 1'b0;
    run(41);

    // Asynchronous reset in the middle of a burst's on-phase.
    acc = cyc + 1;
    expect_at(acc + 2, SIG_LED, 1'b1, "arst_pre_led");
    expect_at(acc + 2, SIG_BUSY, 1'b1, "arst_pre_busy");
    drive(2'd3, 1'b0, 8'd2);
    run(1);
    cmd_valid = 1'b0;
    run(2);
    #2 rst = 1'b1;
    #1;
    cmp("arst_led", led, 1'b0);
    cmp("arst_busy", busy, 1'b0);
    cmp("arst_done", done, 1'b0);
    run(1);
    rst = 1'b0;
    base = cyc;
    for (int k = 1; k <= 20; k++) begin
      expect_at(base + k, SIG_DONE, 1'b0, "arst_no_done");
      expect_at(base + k, SIG_LED, 1'b0, "arst_led_after");
    end
    expect_at(base + 1, SIG_RDY, 1'b1, "arst_rdy");
    run(20);

    // Saved mode after reset is OFF: a single-pulse burst ends with LED low.
    acc = cyc + 1;
    for (int k = 0; k < 16; k++) expect_at(acc + k, SIG_LED, ((k / 8) % 2) == 0, "post_rst_burst_led");
    expect_at(acc + 16, SIG_DONE, 1'b1, "post_rst_done");
    expect_at(acc + 16, SIG_LED, 1'b0, "post_rst_saved_off");
    drive(2'd3, 1'b0, 8'd1);
    run(1);
    cmd_valid = 1'b0;
    run(17);

    cmp("scoreboard_drained", sb.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
